// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule engine.
//   - aes_word_t / aes_block_t : big-endian-indexed word and block types
//                                (bit 0 = MSB of word 0, byte 0)
//   - key_sched_state_t        : controller states
//   - SBOX, RCON               : FIPS-197 substitution box and round constants
//   - rcon_of()                : RCON lookup that returns 0 outside rounds 1..10
package aes_pkg;

  typedef logic [0:31]  aes_word_t;
  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } key_sched_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round counter values outside 1..10 (idle, ready) map to 0 so the
  // combinational round never indexes past the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step (purely combinational).
//   prev : round key r-1 (word 0 in bits 0..31, byte 0 = MSBs)
//   rcon : round constant for round r
//   next : round key r
module aes_key_round
  import aes_pkg::*;
(
  input  aes_block_t prev,
  input  logic [7:0] rcon,
  output aes_block_t next
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t t;
  aes_word_t n0, n1, n2, n3;

  assign w0 = prev[0:31];
  assign w1 = prev[32:63];
  assign w2 = prev[64:95];
  assign w3 = prev[96:127];

  // RotWord moves byte 0 to the end, then SubWord; RCON only touches byte 0.
  assign t = {SBOX[w3[8:15]] ^ rcon, SBOX[w3[16:23]], SBOX[w3[24:31]], SBOX[w3[0:7]]};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule and round-key server.
//   key_valid/key_ready/key_in : cipher key load handshake
//   flush                      : synchronous abort, invalidates all keys
//   busy / done                : expansion in progress / pulse when key 10 is written
//   rk_req/rk_idx              : round-key read request (held until ack or err)
//   rk_ack/rk_err/rk_data      : read response pulses and data
// One round key is produced per clock; reads are granted as soon as the
// requested key exists, so the cipher can start while expansion continues.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,  // only 10 (AES-128) is supported
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [0:127]     key_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  input  logic             rk_req,
  input  logic [IDX_W-1:0] rk_idx,
  output logic             rk_ack,
  output logic             rk_err,
  output logic [0:127]     rk_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  key_sched_state_t state;
  logic [IDX_W-1:0] cnt;    // index of the key being produced this cycle
  logic [IDX_W-1:0] avail;  // keys 0..avail-1 are valid

  aes_block_t rk_mem [0:NUM_ROUNDS];
  aes_block_t last_key;     // copy of rk_mem[cnt-1], feeds the round function
  aes_block_t next_key;
  logic [7:0] rcon_cur;
  logic       load;

  // flush wins over a simultaneous key offer.
  assign load     = key_valid && key_ready && !flush;
  assign rcon_cur = rcon_of(cnt[3:0]);

  aes_key_round u_round (
    .prev (last_key),
    .rcon (rcon_cur),
    .next (next_key)
  );

  // NOTE: the key store is plain storage with no reset; validity is tracked
  // solely by avail, so clearing it would only cost flops and reset fanout.
  always_ff @(posedge clk) begin
    if (load) begin
      rk_mem[0] <= key_in;
      last_key  <= key_in;
    end else if (state == EXPAND && !flush) begin
      rk_mem[cnt] <= next_key;
      last_key    <= next_key;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of avail/state, which the read-grant rule relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rk_ack    <= 1'b0;
      rk_err    <= 1'b0;
      rk_data   <= '0;
      cnt       <= '0;
      avail     <= '0;
    end else begin
      done   <= 1'b0;
      rk_ack <= 1'b0;
      rk_err <= 1'b0;

      if (flush) begin
        // Pending reads are dropped silently; the requester sees neither pulse.
        state     <= IDLE;
        key_ready <= 1'b1;
        busy      <= 1'b0;
        cnt       <= '0;
        avail     <= '0;
      end else begin
        if (load) begin
          // A reload from READY drops keys 1..10 at once via avail.
          state     <= EXPAND;
          key_ready <= 1'b0;
          busy      <= 1'b1;
          cnt       <= ONE;
          avail     <= ONE;
        end else if (state == EXPAND) begin
          avail <= cnt + ONE;
          if (cnt == LAST_IDX) begin
            state     <= READY;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        // Never serve on a load edge: the store is being replaced and the
        // old avail would expose keys of the previous cipher key.
        if (rk_req && !load) begin
          if (rk_idx > LAST_IDX) begin
            rk_err <= 1'b1;
          end else if (rk_idx < avail) begin
            rk_ack  <= 1'b1;
            rk_data <= rk_mem[rk_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] F_R3    = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] F_R9    = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] F_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO  = 128'h0;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [0:127] key_in;
  logic         flush;
  logic         busy;
  logic         done;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_ack;
  logic         rk_err;
  logic [0:127] rk_data;

  int n_cmp = 0;
  int n_bad = 0;

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_ack    (rk_ack),
    .rk_err    (rk_err),
    .rk_data   (rk_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic read_key(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    int n;
    n      = 0;
    rk_req = 1'b1;
    rk_idx = idx;
    do begin
      tick();
      n++;
    end while (!rk_ack && !rk_err && n < 60);
    rk_req = 1'b0;
    check_bit({tag, "_ack"}, rk_ack, 1'b1);
    check({tag, "_data"}, rk_data, exp);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check_bit(tag, done, 1'b1);
  endtask

  initial begin
    int n;
    int done_at;
    logic saw_ack;

    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; flush = 1'b0;
    rk_req = 1'b0; rk_idx = '0;

    // 1: reset values, FIPS key, load-to-done latency
    #12;
    check_bit("rst_key_ready", key_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_ack", rk_ack, 1'b0);
    check_bit("rst_err", rk_err, 1'b0);
    check("rst_data", rk_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    load_key(K_FIPS);
    check_bit("t1_busy", busy, 1'b1);
    check_bit("t1_key_ready", key_ready, 1'b0);
    n = 1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check_int("t1_done_latency", n, 11);
    tick();
    check_bit("t1_done_pulse", done, 1'b0);
    check_bit("t1_ready_busy", busy, 1'b0);
    read_key(4'd1, F_R1, "t1_idx1");
    read_key(4'd10, F_R10, "t1_idx10");

    // 2: all-zero key, idx 10 requested right after load stalls until done
    load_key(K_ZERO);
    rk_req = 1'b1; rk_idx = 4'd10;
    n = 1; done_at = 0;
    while (!rk_ack && n < 40) begin
      tick();
      n++;
      if (done) done_at = n;
    end
    rk_req = 1'b0;
    check_int("t2_done_at", done_at, 11);
    check_int("t2_ack_at", n, 12);
    check("t2_idx10_data", rk_data, Z_R10);
    read_key(4'd1, Z_R1, "t2_idx1");

    // 3: reads overlapping expansion
    load_key(K_FIPS);
    rk_req = 1'b1; rk_idx = 4'd0;
    tick();
    check_bit("t3_idx0_ack", rk_ack, 1'b1);
    check("t3_idx0_data", rk_data, K_FIPS);
    rk_idx = 4'd3;
    n = 1;
    do begin
      tick();
      n++;
    end while (!rk_ack && n < 40);
    rk_req = 1'b0;
    check_int("t3_idx3_cycles", n, 4);
    check("t3_idx3_data", rk_data, F_R3);
    wait_done("t3_done");

    // 4: out-of-range indices
    tick();
    rk_req = 1'b1; rk_idx = 4'd11;
    tick();
    rk_req = 1'b0;
    check_bit("t4_err11", rk_err, 1'b1);
    check_bit("t4_noack11", rk_ack, 1'b0);
    check("t4_data_hold11", rk_data, F_R3);
    tick();
    check_bit("t4_err_pulse", rk_err, 1'b0);
    rk_req = 1'b1; rk_idx = 4'd15;
    tick();
    rk_req = 1'b0;
    check_bit("t4_err15", rk_err, 1'b1);
    check_bit("t4_noack15", rk_ack, 1'b0);
    check("t4_data_hold15", rk_data, F_R3);

    // 5: flush mid-expansion with pending idx 9, then key offered during EXPAND
    load_key(K_ZERO);
    rk_req = 1'b1; rk_idx = 4'd9;
    repeat (4) tick();
    flush = 1'b1; key_valid = 1'b1; key_in = K_FIPS;
    tick();
    flush = 1'b0; key_valid = 1'b0;
    check_bit("t5_flush_busy", busy, 1'b0);
    check_bit("t5_flush_key_ready", key_ready, 1'b1);
    saw_ack = rk_ack;
    repeat (3) begin
      tick();
      saw_ack = saw_ack | rk_ack;
    end
    rk_req = 1'b0;
    check_bit("t5_flush_no_ack", saw_ack, 1'b0);

    load_key(K_FIPS);
    key_valid = 1'b1; key_in = K_ZERO;
    repeat (3) begin
      check_bit("t5_expand_key_ready", key_ready, 1'b0);
      tick();
    end
    key_valid = 1'b0;
    wait_done("t5_done");
    read_key(4'd9, F_R9, "t5_idx9");
    read_key(4'd0, K_FIPS, "t5_idx0");

    // 6: async reset mid-expansion, then load in READY with concurrent read
    load_key(K_ZERO);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("t6_rst_busy", busy, 1'b0);
    check_bit("t6_rst_key_ready", key_ready, 1'b1);
    check("t6_rst_data", rk_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    load_key(K_ZERO);
    wait_done("t6_done");
    tick();
    key_in = K_FIPS; key_valid = 1'b1;
    rk_req = 1'b1; rk_idx = 4'd2;
    tick();
    key_valid = 1'b0;
    check_bit("t6_no_ack_on_load", rk_ack, 1'b0);
    n = 0;
    while (!rk_ack && n < 40) begin
      tick();
      n++;
    end
    rk_req = 1'b0;
    check_bit("t6_idx2_ack", rk_ack, 1'b1);
    check("t6_idx2_data", rk_data, F_R2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
